// File: rtl/clk_period_meter_pkg.sv
// -----------------------------------------------------------------------------
// clk_period_meter_pkg
// Shared definitions for the clock period meter: the measurement FSM state
// encoding and the default counter width used by the interface and the top.
// -----------------------------------------------------------------------------
package clk_period_meter_pkg;

    // Default width of the period / high-time counters and result outputs.
    localparam int DEF_CNT_WIDTH = 24;

    // ST_IDLE    : disabled or waiting for the first rising edge
    // ST_ARMED   : one reference edge seen, no complete period yet
    // ST_MEASURE : locked, every rising edge publishes a result
    // ST_TIMEOUT : no rising edge for TIMEOUT_CYCLES cycles, counters frozen
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_TIMEOUT = 2'd3
    } meter_state_e;

endpackage

// File: rtl/clk_period_meter_if.sv
// -----------------------------------------------------------------------------
// clk_period_meter_if
// Groups the measured signal, the enable and the measurement results of the
// clock period meter.
//   i_Sig      : signal to measure (asynchronous to the meter clock)
//   i_Enable   : level-sensitive measurement enable
//   o_Period   : last complete period, rising edge to rising edge, in cycles
//   o_High     : high time within that period, in cycles
//   o_Valid    : one-cycle pulse when o_Period / o_High update
//   o_Locked   : a full period has been measured and no timeout since
//   o_Timeout  : no rising edge for TIMEOUT_CYCLES cycles
// Modports: master = the side that supplies the signal and reads results,
//           slave  = the meter itself.
// -----------------------------------------------------------------------------
interface clk_period_meter_if
    import clk_period_meter_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
    logic                 i_Sig;
    logic                 i_Enable;
    logic [CNT_WIDTH-1:0] o_Period;
    logic [CNT_WIDTH-1:0] o_High;
    logic                 o_Valid;
    logic                 o_Locked;
    logic                 o_Timeout;

    modport master (
        output i_Sig,
        output i_Enable,
        input  o_Period,
        input  o_High,
        input  o_Valid,
        input  o_Locked,
        input  o_Timeout
    );

    modport slave (
        input  i_Sig,
        input  i_Enable,
        output o_Period,
        output o_High,
        output o_Valid,
        output o_Locked,
        output o_Timeout
    );
endinterface

// File: rtl/clk_period_meter_sig_sync_edge.sv
// -----------------------------------------------------------------------------
// sig_sync_edge
// Brings an asynchronous level into the clk_i domain through a SYNC_STAGES
// flip-flop chain and flags its rising and falling edges. Reusable for
// buttons, UART RX lines and similar slow inputs.
//   clk_i    : destination clock
//   rst_i    : asynchronous active-high reset (chain and edge history to 0)
//   async_i  : asynchronous input level
//   level_o  : synchronized level
//   rise_o   : high for one cycle when level_o goes 0 -> 1
//   fall_o   : high for one cycle when level_o goes 1 -> 0
// -----------------------------------------------------------------------------
module sig_sync_edge
    import clk_period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q       <= '0;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], async_i};
            level_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  level_o & ~level_prev_q;
    assign fall_o  = ~level_o &  level_prev_q;
endmodule

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
// Measures a slow periodic signal in i_Clk cycles: the period between two
// rising edges and the high time within it. Reports lock once a full period
// has been measured, and timeout when edges stop arriving.
//   i_Clk  : system clock, the only clock domain
//   i_Rst  : asynchronous active-high reset
//   bus    : clk_period_meter_if.slave (i_Sig, i_Enable in; o_Period,
//            o_High, o_Valid, o_Locked, o_Timeout out, all registered)
// Parameters:
//   CNT_WIDTH      : counter / result width
//   TIMEOUT_CYCLES : cycles without a rising edge before timeout,
//                    2 .. 2^CNT_WIDTH-1
//   SYNC_STAGES    : input synchronizer depth, at least 2
// -----------------------------------------------------------------------------
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int                   CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT_CYCLES = CNT_WIDTH'(24'd10_000_000),
    parameter int                   SYNC_STAGES    = 2
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    clk_period_meter_if.slave   bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic sig_s;
    logic sig_rise;
    logic sig_fall_unused;

    sig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (i_Clk),
        .rst_i   (i_Rst),
        .async_i (bus.i_Sig),
        .level_o (sig_s),
        .rise_o  (sig_rise),
        .fall_o  (sig_fall_unused)
    );

    meter_state_e         state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] high_cnt_q;
    logic [CNT_WIDTH-1:0] period_q;
    logic [CNT_WIDTH-1:0] high_q;
    logic                 valid_q;
    logic                 locked_q;
    logic                 timeout_q;

    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] high_cnt_d;
    logic                 at_limit;

    // The timeout check stops counting at TIMEOUT_CYCLES, so the increment
    // never wraps.
    assign cnt_d      = cnt_q + CNT_ONE;
    assign high_cnt_d = high_cnt_q + CNT_WIDTH'(sig_s);
    assign at_limit   = (cnt_q == TIMEOUT_CYCLES);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            high_cnt_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            // Disable overrides everything, including a rise in the same cycle.
            if (!bus.i_Enable) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                high_cnt_q <= '0;
                locked_q   <= 1'b0;
                timeout_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sig_rise) begin
                            state_q    <= ST_ARMED;
                            cnt_q      <= CNT_ONE;
                            high_cnt_q <= CNT_ONE;
                        end
                    end
                    ST_ARMED, ST_MEASURE: begin
                        // A rise on the limit cycle still completes the period.
                        if (sig_rise) begin
                            period_q   <= cnt_q;
                            high_q     <= high_cnt_q;
                            valid_q    <= 1'b1;
                            locked_q   <= 1'b1;
                            cnt_q      <= CNT_ONE;
                            high_cnt_q <= CNT_ONE;
                            state_q    <= ST_MEASURE;
                        end else if (at_limit) begin
                            state_q    <= ST_TIMEOUT;
                            timeout_q  <= 1'b1;
                            locked_q   <= 1'b0;
                        end else begin
                            cnt_q      <= cnt_d;
                            high_cnt_q <= high_cnt_d;
                        end
                    end
                    ST_TIMEOUT: begin
                        // The period ending here started before the timeout,
                        // so it is only used as a new reference edge.
                        if (sig_rise) begin
                            timeout_q  <= 1'b0;
                            cnt_q      <= CNT_ONE;
                            high_cnt_q <= CNT_ONE;
                            state_q    <= ST_ARMED;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_Period  = period_q;
    assign bus.o_High    = high_q;
    assign bus.o_Valid   = valid_q;
    assign bus.o_Locked  = locked_q;
    assign bus.o_Timeout = timeout_q;
endmodule
